cpu_control_unit: RTL

//  Multi-cycle control sequencer that drives the control side of cpu_datapath.

---
 rtl/cpu_control_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_control_unit.sv
// Multi-cycle control sequencer for cpu_datapath.
// Fetches a 16-bit instruction per request/valid handshake, decodes it, and
// drives register-file addresses, ALU/mux selects, the immediate and a
// single-cycle write strobe. Owns the PC and a carry flag for jump-on-carry.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_FETCH  | instr_req high, waiting for instr_valid at pc_out
// ST_DECODE | decoded controls visible, no write
// ST_EXEC   | controls held, write_en pulse, PC/carry update at exit
// ST_HALTED | HALT executed, waiting for start to restart at RESET_PC
module cpu_control_unit #(
  parameter int unsigned         DATA_WIDTH = 8,
  parameter int unsigned         PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  instr_req,
  output logic [PC_WIDTH-1:0]   pc_out,
  input  logic                  instr_valid,
  input  logic [15:0]           instr_data,
  input  logic                  carry_in,
  output logic                  write_en,
  output logic [2:0]            write_addr,
  output logic [2:0]            read_addr1,
  output logic [2:0]            read_addr2,
  output logic [2:0]            alu_sel,
  output logic                  mux_sel,
  output logic [DATA_WIDTH-1:0] immediate_data,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal_op,
  output logic                  carry_flag
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_ILL  = 4'hA;
  localparam logic [3:0] OP_ANDI = 4'hB;
  localparam logic [3:0] OP_ORI  = 4'hC;
  localparam logic [3:0] OP_LI   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state, next_state;

  // Only the fields EXEC still needs are kept from the fetched word;
  // everything else is decoded straight into the output registers.
  logic [3:0] op_q;
  logic [2:0] rd_q;
  logic [7:0] tgt_q;

  logic       accept;
  logic [2:0] dec_alu_sel;
  logic [2:0] dec_read1;
  logic [2:0] dec_read2;
  logic       dec_mux_sel;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_SHR) ||
           (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LI});
  endfunction

  assign accept    = (state == ST_FETCH) && instr_valid;
  assign instr_req = (state == ST_FETCH);
  assign busy      = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign halted    = (state == ST_HALTED);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_FETCH;
      ST_FETCH:  if (instr_valid) next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = (op_q == OP_HALT) ? ST_HALTED : ST_FETCH;
      ST_HALTED: if (start) next_state = ST_FETCH;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Field decode of the incoming word; registered on accept so the
  // controls are already stable during DECODE.
  always_comb begin
    dec_alu_sel = '0;
    dec_read1   = '0;
    dec_read2   = '0;
    dec_mux_sel = 1'b0;
    case (instr_data[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        dec_alu_sel = 3'(instr_data[15:12] - 4'd1);
        dec_read1   = instr_data[8:6];
        dec_read2   = instr_data[5:3];
      end
      OP_ADDI: begin
        dec_alu_sel = 3'b000;
        dec_read1   = instr_data[11:9];
        dec_mux_sel = 1'b1;
      end
      OP_ANDI: begin
        dec_alu_sel = 3'b010;
        dec_read1   = instr_data[11:9];
        dec_mux_sel = 1'b1;
      end
      OP_ORI: begin
        dec_alu_sel = 3'b011;
        dec_read1   = instr_data[11:9];
        dec_mux_sel = 1'b1;
      end
      OP_LI: begin
        dec_alu_sel = 3'b111;
        dec_read1   = instr_data[11:9];
        dec_mux_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // Latch the instruction fields and decoded controls on fetch accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q           <= '0;
      rd_q           <= '0;
      tgt_q          <= '0;
      alu_sel        <= '0;
      read_addr1     <= '0;
      read_addr2     <= '0;
      mux_sel        <= 1'b0;
      immediate_data <= '0;
    end else if (accept) begin
      op_q           <= instr_data[15:12];
      rd_q           <= instr_data[11:9];
      tgt_q          <= instr_data[7:0];
      alu_sel        <= dec_alu_sel;
      read_addr1     <= dec_read1;
      read_addr2     <= dec_read2;
      mux_sel        <= dec_mux_sel;
      immediate_data <= DATA_WIDTH'(instr_data[7:0]);
    end
  end

  // Write strobe: raised entering EXEC for ALU ops, dropped leaving it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
    end else if (state == ST_DECODE) begin
      write_en   <= is_alu_op(op_q);
      write_addr <= rd_q;
    end else begin
      write_en   <= 1'b0;
    end
  end

  // PC, carry and illegal flag update at the end of EXEC, cleared on restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out     <= RESET_PC;
      carry_flag <= 1'b0;
      illegal_op <= 1'b0;
    end else if (state == ST_EXEC) begin
      case (op_q)
        OP_JMP:  pc_out <= PC_WIDTH'(tgt_q);
        OP_JC:   pc_out <= carry_flag ? PC_WIDTH'(tgt_q) : pc_out + PC_WIDTH'(1);
        OP_HALT: pc_out <= pc_out;
        default: pc_out <= pc_out + PC_WIDTH'(1);
      endcase
      if (op_q inside {OP_ADD, OP_SUB, OP_ADDI}) carry_flag <= carry_in;
      if (op_q == OP_ILL) illegal_op <= 1'b1;
    end else if (state == ST_HALTED && start) begin
      pc_out     <= RESET_PC;
      carry_flag <= 1'b0;
      illegal_op <= 1'b0;
    end
  end

endmodule
